// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-in, serial-out shift register with framing flags.
// Accepts a WIDTH-bit word over a valid/ready load handshake and emits it one
// bit per enabled clock. Back-to-back loads stream with no idle gap.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   d_in       parallel word to transmit
//   load_valid d_in is valid for loading
//   load_ready block can accept a word this cycle (combinational)
//   shift_en   advance the serial stream this cycle; 0 = stall
//   d_out      serial data bit (registered)
//   out_valid  d_out carries a payload bit (registered)
//   last       d_out is the final bit of the current word (registered)
//   busy       a word is in flight (registered)
//   word_cnt   count of fully transmitted words, wraps 255 -> 0
module piso_shift_reg #(
   parameter int unsigned WIDTH     = 2,
   parameter int unsigned LSB_FIRST = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d_in,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic             shift_en,
   output logic             d_out,
   output logic             out_valid,
   output logic             last,
   output logic             busy,
   output logic [7:0]       word_cnt
);

   localparam int unsigned     CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;

   logic [1:0]       state_q,   state_nxt;
   logic [WIDTH-1:0] shreg_q,   shreg_nxt;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_nxt;
   logic [7:0]       word_cnt_nxt;
   logic             last_int;
   logic             load_fire;
   logic [WIDTH-1:0] shreg_shifted;

   // Final payload bit currently presented on d_out.
   assign last_int   = (state_q == SHIFT) && (bit_cnt_q == LAST_CNT);
   assign load_ready = !reset && ((state_q == IDLE) || (last_int && shift_en));
   assign load_fire  = load_valid && load_ready;

   // Shift toward the output end, zero fill.
   always_comb begin
      shreg_shifted = '0;
      if (LSB_FIRST != 0) shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
      else                shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
   end

   // Next-state logic.
   always_comb begin
      state_nxt    = state_q;
      shreg_nxt    = shreg_q;
      bit_cnt_nxt  = bit_cnt_q;
      word_cnt_nxt = word_cnt;
      case (state_q)
         IDLE: begin
            if (load_fire) begin
               shreg_nxt   = d_in;
               bit_cnt_nxt = '0;
               state_nxt   = SHIFT;
            end
         end
         SHIFT: begin
            if (shift_en) begin
               if (last_int) begin
                  word_cnt_nxt = word_cnt + 8'd1;
                  if (load_fire) begin
                     // Seamless handoff: next word's first bit follows directly.
                     shreg_nxt   = d_in;
                     bit_cnt_nxt = '0;
                  end else begin
                     shreg_nxt   = shreg_shifted;
                     bit_cnt_nxt = '0;
                     state_nxt   = IDLE;
                  end
               end else begin
                  shreg_nxt   = shreg_shifted;
                  bit_cnt_nxt = bit_cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_nxt   = IDLE;
            shreg_nxt   = '0;
            bit_cnt_nxt = '0;
         end
      endcase
   end

   // State and registered outputs; flags derive from next-state values so
   // they line up with the registers they describe.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         word_cnt  <= '0;
         d_out     <= 1'b0;
         out_valid <= 1'b0;
         last      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         shreg_q   <= shreg_nxt;
         bit_cnt_q <= bit_cnt_nxt;
         word_cnt  <= word_cnt_nxt;
         out_valid <= (state_nxt == SHIFT);
         busy      <= (state_nxt == SHIFT);
         last      <= (state_nxt == SHIFT) && (bit_cnt_nxt == LAST_CNT);
         if (state_nxt == SHIFT)
            d_out <= (LSB_FIRST != 0) ? shreg_nxt[0] : shreg_nxt[WIDTH-1];
         else
            d_out <= 1'b0;
      end
   end

endmodule

// File: tb/tb_piso_shift_reg.sv
module tb_piso_shift_reg;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   // 8-bit MSB-first instance
   logic [7:0] din8 = '0;
   logic       lv8 = 1'b0, se8 = 1'b0;
   logic       lr8, do8, ov8, last8, busy8;
   logic [7:0] wc8;
   // 4-bit LSB-first instance
   logic [3:0] din4 = '0;
   logic       lv4 = 1'b0, se4 = 1'b0;
   logic       lr4, do4, ov4, last4, busy4;
   logic [7:0] wc4;
   // 2-bit MSB-first instance
   logic [1:0] din2 = '0;
   logic       lv2 = 1'b0, se2 = 1'b0;
   logic       lr2, do2, ov2, last2, busy2;
   logic [7:0] wc2;

   piso_shift_reg #(.WIDTH(8), .LSB_FIRST(0)) u8 (
      .clk(clk), .reset(reset), .d_in(din8), .load_valid(lv8), .load_ready(lr8),
      .shift_en(se8), .d_out(do8), .out_valid(ov8), .last(last8), .busy(busy8),
      .word_cnt(wc8));
   piso_shift_reg #(.WIDTH(4), .LSB_FIRST(1)) u4 (
      .clk(clk), .reset(reset), .d_in(din4), .load_valid(lv4), .load_ready(lr4),
      .shift_en(se4), .d_out(do4), .out_valid(ov4), .last(last4), .busy(busy4),
      .word_cnt(wc4));
   piso_shift_reg #(.WIDTH(2), .LSB_FIRST(0)) u2 (
      .clk(clk), .reset(reset), .d_in(din2), .load_valid(lv2), .load_ready(lr2),
      .shift_en(se2), .d_out(do2), .out_valid(ov2), .last(last2), .busy(busy2),
      .word_cnt(wc2));

   int n_checks = 0;
   int n_fail   = 0;
   logic sbq[$];

   typedef struct {
      logic       lv;
      logic [7:0] din;
      logic       se;
      logic       dout;
      logic       ov;
      logic       last;
      logic       rdy;
   } vec_t;
   vec_t tbl[18];

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard for the 8-bit instance: expected bits queued on load,
   // popped when a bit is consumed (out_valid && shift_en).
   task automatic sb();
      logic e;
      if (reset) begin
         sbq.delete();
      end else begin
         if (ov8 && se8) begin
            if (sbq.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_underflow: got payload bit %0b expected none at %0t", do8, $time);
            end else begin
               e = sbq.pop_front();
               chk1("sb_bit", do8, e);
            end
         end
         if (lv8 && lr8)
            for (int i = 7; i >= 0; i--) sbq.push_back(din8[i]);
      end
   endtask

   // One clock: drive after the rising edge, sample on the falling edge.
   task automatic cyc(input logic rst, input logic lv, input logic [7:0] din,
                      input logic se, input int sel);
      @(posedge clk);
      #1;
      reset = rst;
      lv8 = 1'b0; lv4 = 1'b0; lv2 = 1'b0;
      se8 = 1'b1; se4 = 1'b1; se2 = 1'b1;
      case (sel)
         8: begin lv8 = lv; din8 = din;      se8 = se; end
         4: begin lv4 = lv; din4 = din[3:0]; se4 = se; end
         default: begin lv2 = lv; din2 = din[1:0]; se2 = se; end
      endcase
      @(negedge clk);
      sb();
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [7:0] a5, c3c;
      logic [3:0] w4;
      logic [1:0] rx;
      int n, guard;
      a5 = 8'hA5;
      c3c = 8'h3C;

      // Back-to-back stream table: A5 then 3C presented during last.
      tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 8; i++)
         tbl[1+i] = '{(i == 7), ((i == 7) ? 8'h3C : 8'h00), 1'b1, a5[7-i], 1'b1, (i == 7), (i == 7)};
      for (int i = 0; i < 8; i++)
         tbl[9+i] = '{1'b0, 8'h00, 1'b1, c3c[7-i], 1'b1, (i == 7), (i == 7)};
      tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

      // Reset then idle
      cyc(1'b1, 1'b1, 8'h00, 1'b1, 8);
      chk1("ready_in_reset", lr8, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 8);
      chk1("rst_dout", do8, 1'b0);
      chk1("rst_ov", ov8, 1'b0);
      chk1("rst_busy", busy8, 1'b0);
      chk1("rst_last", last8, 1'b0);
      chk8("rst_wc8", wc8, 8'd0);
      chk1("rst_ready", lr8, 1'b1);
      chk8("rst_wc4", wc4, 8'd0);
      chk8("rst_wc2", wc2, 8'd0);

      // Table-driven back-to-back
      for (int k = 0; k < 18; k++) begin
         cyc(1'b0, tbl[k].lv, tbl[k].din, tbl[k].se, 8);
         chk1("tbl_dout", do8, tbl[k].dout);
         chk1("tbl_ov", ov8, tbl[k].ov);
         chk1("tbl_busy", busy8, tbl[k].ov);
         chk1("tbl_last", last8, tbl[k].last);
         chk1("tbl_ready", lr8, tbl[k].rdy);
      end
      chk8("b2b_wc", wc8, 8'd2);

      // Stall with a spurious load request while not ready
      cyc(1'b0, 1'b1, 8'hF0, 1'b1, 8);
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 8);
      chk1("stall_b0", do8, 1'b1);
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 8);
      chk1("stall_b1", do8, 1'b1);
      for (int s = 0; s < 3; s++) begin
         cyc(1'b0, 1'b1, 8'h00, 1'b0, 8);
         chk1("stall_hold_dout", do8, 1'b1);
         chk1("stall_hold_ov", ov8, 1'b1);
         chk1("stall_hold_last", last8, 1'b0);
         chk1("stall_not_ready", lr8, 1'b0);
      end
      n = 2;
      guard = 0;
      do begin
         cyc(1'b0, 1'b0, 8'h00, 1'b1, 8);
         if (ov8) n++;
         guard++;
      end while (ov8 && guard < 20);
      chki("stall_timeout", (guard < 20) ? 1 : 0, 1);
      chki("stall_bits", n, 8);
      chk8("stall_wc", wc8, 8'd3);

      // Reset mid-word
      cyc(1'b0, 1'b1, 8'hFF, 1'b1, 8);
      for (int b = 0; b < 4; b++) begin
         cyc(1'b0, 1'b0, 8'h00, 1'b1, 8);
         chk1("mid_bits", do8, 1'b1);
      end
      cyc(1'b1, 1'b0, 8'h00, 1'b1, 8);
      chk1("mid_ready_in_reset", lr8, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 8);
      chk1("mid_dout", do8, 1'b0);
      chk1("mid_ov", ov8, 1'b0);
      chk1("mid_last", last8, 1'b0);
      chk8("mid_wc", wc8, 8'd0);
      chk1("mid_ready", lr8, 1'b1);
      cyc(1'b0, 1'b1, 8'h5A, 1'b1, 8);
      guard = 0;
      do begin
         cyc(1'b0, 1'b0, 8'h00, 1'b1, 8);
         guard++;
      end while (ov8 && guard < 20);
      chki("mid_timeout", (guard < 20) ? 1 : 0, 1);
      chk8("mid_wc_after", wc8, 8'd1);
      chki("sb_drained", sbq.size(), 0);

      // WIDTH=2, load 01, with a shift_reg-style receiver model
      rx = 2'b00;
      cyc(1'b0, 1'b1, 8'h01, 1'b1, 2);
      chk1("w2_ready", lr2, 1'b1);
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 2);
      chk1("w2_c1_dout", do2, 1'b0);
      chk1("w2_c1_last", last2, 1'b0);
      chk1("w2_c1_ov", ov2, 1'b1);
      rx = {rx[0], do2};
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 2);
      chk1("w2_c2_dout", do2, 1'b1);
      chk1("w2_c2_last", last2, 1'b1);
      rx = {rx[0], do2};
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 2);
      chk1("w2_c3_ov", ov2, 1'b0);
      chk8("w2_wc", wc2, 8'd1);
      chk8("w2_rx", {6'd0, rx}, 8'h01);

      // LSB_FIRST, WIDTH=4, load 0011
      w4 = 4'b0011;
      cyc(1'b0, 1'b1, 8'h03, 1'b1, 4);
      for (int j = 0; j < 4; j++) begin
         cyc(1'b0, 1'b0, 8'h00, 1'b1, 4);
         chk1("w4_dout", do4, w4[j]);
         chk1("w4_ov", ov4, 1'b1);
         chk1("w4_last", last4, (j == 3));
      end
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 4);
      chk1("w4_idle_ov", ov4, 1'b0);
      chk8("w4_wc", wc4, 8'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/piso_shift_reg.md
Name: piso_shift_reg

Overview:
Parallel-in, serial-out shift register: the transmit end for the serial-in `shift_reg`. It accepts a WIDTH-bit word over a valid/ready load handshake and emits it one bit per enabled clock on `d_out`, with framing flags. Back-to-back loads stream with no idle gap. It drives a `shift_reg` directly: WIDTH enabled cycles after the first bit appears, the receiver holds the original word.

Parameters:
WIDTH, 2, word length in bits; legal range 2..32.
LSB_FIRST, 0, 0 = MSB transmitted first (matches `shift_reg`, which enters new bits at bit 0); 1 = LSB first.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
d_in  input  WIDTH  parallel word to transmit
load_valid  input  1  `d_in` is valid for loading
load_ready  output  1  block can accept a word this cycle
shift_en  input  1  advance the serial stream this cycle; 0 = stall
d_out  output  1  serial data bit
out_valid  output  1  `d_out` carries a payload bit
last  output  1  `d_out` is the final bit of the current word
busy  output  1  a word is in flight (state SHIFT)
word_cnt  output  8  count of fully transmitted words; wraps 255 -> 0

Behaviour:
- Interface: one clock, `clk`. Reset `reset` is synchronous and active-high; it is sampled only on the rising edge of `clk`.
- States: IDLE, SHIFT. Registers: `shreg[WIDTH-1:0]`, `bit_cnt` (clog2(WIDTH) bits), `word_cnt`.
- Reset: state = IDLE, `shreg` = 0, `bit_cnt` = 0, `word_cnt` = 0.
  - Registered outputs after the reset edge: `d_out` = 0, `out_valid` = 0, `last` = 0, `busy` = 0.
  - `load_ready` is forced to 0 while `reset` = 1.
  - Reset mid-word abandons the word silently; `word_cnt` does not increment.
- `load_ready` (combinational) = !reset && (state == IDLE || (last && shift_en)).
- Load: occurs on an edge where `load_valid && load_ready`.
  - `shreg` <= `d_in`, `bit_cnt` <= 0, state <= SHIFT.
  - The first bit is on `d_out` the cycle after the load edge, so latency is 1 clock.
  - `shift_en` is not required on the load cycle.
- Output bit: `d_out` = `shreg[WIDTH-1]` if LSB_FIRST = 0, else `shreg[0]`. `d_out` = 0 in IDLE.
- SHIFT with `shift_en` = 1, each edge:
  - `shreg` shifts toward the output end, filling with 0.
  - `bit_cnt` increments.
- SHIFT with `shift_en` = 0: all state holds, and `d_out`, `out_valid` and `last` are stable.
- Flag values:
  - `out_valid` = (state == SHIFT).
  - `busy` = `out_valid`.
  - `last` = (state == SHIFT && `bit_cnt` == WIDTH-1).
- End of word: on an edge with `last && shift_en`:
  - `word_cnt` increments (8-bit wrap).
  - If a load also occurs that edge, the new word's first bit follows on the next cycle with no gap, and state stays SHIFT.
  - Otherwise state <= IDLE.
- `load_valid` while `load_ready` = 0 is ignored; the upstream must hold the word until ready.
- `load_valid` with X on `d_in` while not ready must not corrupt `shreg`.
- No other state exists. Illegal encodings recover to IDLE.

Test Plan:
- Reset then idle: assert `reset` 1 cycle, `load_valid` = 0 -> `d_out` = 0, `out_valid` = 0, `busy` = 0, `word_cnt` = 0, `load_ready` = 1 one cycle after reset deasserts.
- WIDTH=2, load 2'b01, `shift_en` = 1:
  - Cycle 1: `d_out` = 0, `last` = 0. Cycle 2: `d_out` = 1, `last` = 1. Cycle 3: IDLE, `word_cnt` = 1.
  - Loop `d_out` into `shift_reg.d_in`: its `d_out` = 2'b01 after word end.
- Back-to-back, WIDTH=8: load 8'hA5, then 8'h3C presented during `last` -> serial stream 1010_0101_0011_1100 with `out_valid` continuously 1 for 16 cycles, `word_cnt` = 2.
- Stall: WIDTH=8, load 8'hF0, drop `shift_en` for 3 cycles after bit 2 -> `d_out` holds bit 2 value (1), `bit_cnt` frozen; stream resumes intact, 8 payload bits total.
- LSB_FIRST=1, WIDTH=4, load 4'b0011 -> `d_out` sequence 1,1,0,0; `last` on 4th bit.
- Reset mid-word: WIDTH=8, load 8'hFF, assert `reset` after bit 3 -> next cycle `d_out` = 0, `out_valid` = 0, `word_cnt` unchanged (0); a new load afterward transmits correctly.
